tff_count_sequencer: RTL and testbench

Controller that sequences a WIDTH-bit bank of toggle flip-flops into a programmable up/down counter with parallel load, run-to-limit and abort. Every bit of the bank is updated only by toggling: Q <= Q ^ T. The block computes the per-bit T vector each cycle and owns the FSM that decides when the bank loads, steps or holds. It is the sequencing layer above the lab T-flip-flop cells and exports T_out so the cell bank can be probed or replaced.

---
 rtl/tff_count_sequencer.sv | 108 ++++++++++
 tb/tb_tff_count_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tff_count_sequencer.sv
// rtl/tff_count_sequencer.sv - sequencer driving a WIDTH-bit toggle-flop bank as a loadable up/down counter
// The bank only ever toggles (Q <= Q ^ T); this block chooses T and runs the IDLE/RUN/DONE FSM.
module tff_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] T_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] up_t, dn_t, t_vec;
  logic             up_acc, dn_acc;
  logic             at_limit;

  // Ripple-carry toggle terms: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_t   = '0;
    dn_t   = '0;
    up_acc = 1'b1;
    dn_acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = up_acc;
      dn_t[i] = dn_acc;
      up_acc  = up_acc & q_q[i];
      dn_acc  = dn_acc & ~q_q[i];
    end
  end

  assign at_limit = (q_q == limit);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    t_vec   = '0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          t_vec = q_q ^ load_val;
        end else if (start) begin
          state_d = RUN;
          dir_d   = dir;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (at_limit) begin
          state_d = DONE;
        end else begin
          t_vec  = dir_q ? up_t : dn_t;
          wrap_d = dir_q ? (&q_q) : ~(|q_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      t_vec = '0;
    end
    q_d = q_q ^ t_vec;
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      q_q     <= q_d;
    end
  end

  assign Q     = q_q;
  assign T_out = t_vec;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb/tb_tff_count_sequencer.sv - directed self-checking bench for tff_count_sequencer
module tb_tff_count_sequencer;

  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic       stop = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] limit = 4'h0;
  logic [3:0] Q;
  logic [3:0] T_out;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  tff_count_sequencer #(.WIDTH(4)) dut (
    .Clk      (Clk),
    .rst      (rst),
    .start    (start),
    .dir      (dir),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .Q        (Q),
    .T_out    (T_out),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
    chk("load_q", Q, v);
  endtask

  task automatic chk_status(input string tag, input logic [3:0] q, input logic b, input logic d, input logic w);
    chk({tag, "_q"}, Q, q);
    chk({tag, "_busy"}, busy, b);
    chk({tag, "_done"}, done, d);
    chk({tag, "_wrap"}, wrap, w);
  endtask

  initial begin
    // Reset asserted mid-cycle, with load already high: T_out must still be 0.
    #3;
    rst = 1'b1;
    load = 1'b1;
    load_val = 4'hA;
    #1;
    chk_status("rst", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_tout", T_out, 4'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("load_tout", T_out, 4'hA);
    tick();
    load = 1'b0;
    chk("load_a_q", Q, 4'hA);

    // Up run 3 -> 7.
    do_load(4'h3);
    start = 1'b1;
    dir = 1'b1;
    limit = 4'h7;
    tick();
    start = 1'b0;
    chk_status("up_e0", 4'h3, 1'b1, 1'b0, 1'b0);
    chk("up_tout", T_out, 4'b0111);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_status("up_step", 4'(3 + k), 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_status("up_done", 4'h7, 1'b0, 1'b1, 1'b0);
    tick();
    chk_status("up_idle", 4'h7, 1'b0, 1'b0, 1'b0);

    // Down run 1 -> 0 -> 15 -> 14 with one wrap.
    do_load(4'h1);
    start = 1'b1;
    dir = 1'b0;
    limit = 4'hE;
    tick();
    start = 1'b0;
    chk_status("dn_e0", 4'h1, 1'b1, 1'b0, 1'b0);
    chk("dn_tout", T_out, 4'b0001);
    tick();
    chk_status("dn_s1", 4'h0, 1'b1, 1'b0, 1'b0);
    chk("dn_tout0", T_out, 4'hF);
    tick();
    chk_status("dn_s2", 4'hF, 1'b1, 1'b0, 1'b1);
    tick();
    chk_status("dn_s3", 4'hE, 1'b1, 1'b0, 1'b0);
    tick();
    chk_status("dn_done", 4'hE, 1'b0, 1'b1, 1'b0);
    tick();
    chk_status("dn_idle", 4'hE, 1'b0, 1'b0, 1'b0);

    // Abort at Q = 5; load/start during the run are ignored.
    do_load(4'h0);
    start = 1'b1;
    dir = 1'b1;
    limit = 4'hC;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ab_q2", Q, 4'h2);
    load = 1'b1;
    load_val = 4'h9;
    start = 1'b1;
    #1;
    chk("ab_run_tout", T_out, 4'b0001);
    tick();
    load = 1'b0;
    start = 1'b0;
    chk_status("ab_ign", 4'h3, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("ab_q5", Q, 4'h5);
    stop = 1'b1;
    #1;
    chk("ab_stop_tout", T_out, 4'h0);
    tick();
    stop = 1'b0;
    chk_status("ab_stop", 4'h5, 1'b0, 1'b0, 1'b0);
    tick();
    chk_status("ab_after", 4'h5, 1'b0, 1'b0, 1'b0);
    load = 1'b1;
    load_val = 4'h6;
    start = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b0;
    chk_status("ld_st_both", 4'h6, 1'b0, 1'b0, 1'b0);
    tick();
    chk_status("ld_st_idle", 4'h6, 1'b0, 1'b0, 1'b0);

    // Zero distance.
    do_load(4'h9);
    start = 1'b1;
    dir = 1'b1;
    limit = 4'h9;
    tick();
    start = 1'b0;
    chk_status("zd_e0", 4'h9, 1'b1, 1'b0, 1'b0);
    chk("zd_tout", T_out, 4'h0);
    tick();
    chk_status("zd_done", 4'h9, 1'b0, 1'b1, 1'b0);
    tick();
    chk_status("zd_idle", 4'h9, 1'b0, 1'b0, 1'b0);

    // Direction latched at start; flipping dir mid-run has no effect.
    start = 1'b1;
    dir = 1'b1;
    limit = 4'hB;
    tick();
    start = 1'b0;
    dir = 1'b0;
    tick();
    chk_status("dl_s1", 4'hA, 1'b1, 1'b0, 1'b0);
    tick();
    chk_status("dl_s2", 4'hB, 1'b1, 1'b0, 1'b0);
    tick();
    chk_status("dl_done", 4'hB, 1'b0, 1'b1, 1'b0);
    tick();

    // Reset mid-run at Q = 6.
    do_load(4'h0);
    start = 1'b1;
    dir = 1'b1;
    limit = 4'hF;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk_status("mr_q6", 4'h6, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_status("mr_rst", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("mr_rst_tout", T_out, 4'h0);
    tick();
    rst = 1'b0;
    tick();
    chk_status("mr_release", 4'h0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    dir = 1'b1;
    limit = 4'h2;
    tick();
    start = 1'b0;
    chk_status("mr_e0", 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk_status("mr_s2", 4'h2, 1'b1, 1'b0, 1'b0);
    tick();
    chk_status("mr_done", 4'h2, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
